// File: rtl/aes_round_sequencer.sv
// Iterative AES-128 controller: runs one block ten times through an external round datapath,
// owning the datapath's bubble flag and Rcon, and returns the ciphertext on a valid/ready port.
module aes_round_sequencer #(
  parameter int ROUND_LAT = 4,
  parameter int WD_SLACK  = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_text,
  input  logic [127:0] in_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_text,
  output logic [127:0] rd_state_out,
  output logic [127:0] rd_key_out,
  output logic [7:0]   rd_rcon_out,
  output logic         rd_empty_out,
  input  logic [127:0] rd_state_in,
  input  logic [127:0] rd_key_in,
  input  logic [7:0]   rd_rcon_in,
  input  logic         rd_empty_in,
  output logic         busy,
  output logic [3:0]   round,
  output logic         error
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  localparam int              WD_LIMIT  = ROUND_LAT + WD_SLACK;
  localparam int              WD_W      = $clog2(WD_LIMIT + 1) + 1;
  localparam logic [WD_W-1:0] WD_FIRE   = WD_W'(WD_LIMIT - 1);
  localparam logic [7:0]      RCON_LAST = 8'h36;

  state_t          state;
  logic [WD_W-1:0] wd_count;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // The rd_*_out registers are the working state/key/rcon: they hold steady through WAIT
  // and are reloaded from the datapath return before the next issue.
  // NOTE: every register here is assigned with <= so all updates take effect together at the edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      in_ready     <= 1'b0;
      out_valid    <= 1'b0;
      out_text     <= '0;
      rd_state_out <= '0;
      rd_key_out   <= '0;
      rd_rcon_out  <= '0;
      rd_empty_out <= 1'b1;
      busy         <= 1'b0;
      round        <= '0;
      error        <= 1'b0;
      wd_count     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (in_ready && in_valid) begin
            in_ready     <= 1'b0;
            busy         <= 1'b1;
            round        <= 4'd1;
            rd_state_out <= in_text ^ in_key;
            rd_key_out   <= in_key;
            rd_rcon_out  <= 8'h01;
            rd_empty_out <= 1'b0;
            state        <= ISSUE;
          end
        end

        ISSUE: begin
          rd_empty_out <= 1'b1;
          // Loaded with 1 so the count equals cycles elapsed since the issue cycle.
          wd_count     <= {{(WD_W-1){1'b0}}, 1'b1};
          state        <= WAIT;
        end

        WAIT: begin
          if (!rd_empty_in) begin
            if (rd_rcon_in != rd_rcon_out) begin
              error    <= 1'b1;
              busy     <= 1'b0;
              round    <= '0;
              in_ready <= 1'b1;
              state    <= IDLE;
            end else if (rd_rcon_out == RCON_LAST) begin
              out_text  <= rd_state_in;
              out_valid <= 1'b1;
              state     <= DONE;
            end else begin
              rd_state_out <= rd_state_in;
              rd_key_out   <= rd_key_in;
              rd_rcon_out  <= xtime(rd_rcon_out);
              round        <= round + 4'd1;
              rd_empty_out <= 1'b0;
              state        <= ISSUE;
            end
          end else if (wd_count >= WD_FIRE) begin
            error    <= 1'b1;
            busy     <= 1'b0;
            round    <= '0;
            in_ready <= 1'b1;
            state    <= IDLE;
          end else begin
            wd_count <= wd_count + 1'b1;
          end
        end

        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            round     <= '0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
      endcase
    end
  end

endmodule
